// File: rtl/snoop_bus_initiator_pkg.sv
// Shared bus-side snoop definitions: bus-op, snoop-result and MESI codes, plus
// the initiator FSM state encoding.
package snoop_bus_initiator_pkg;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RWIM       = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNOOP_NOHIT = 2'd0,
    SNOOP_HIT   = 2'd1,
    SNOOP_HITM  = 2'd2
  } snoop_res_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SNOOP,
    ST_WB_WAIT,
    ST_DONE
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Code 3 from the peers is folded into HITM.
  function automatic snoop_res_e norm_result(input logic [1:0] r);
    return r[1] ? SNOOP_HITM : (r[0] ? SNOOP_HIT : SNOOP_NOHIT);
  endfunction

endpackage

// File: rtl/snoop_bus_initiator_snoop_next_state.sv
// Combinational (bus op, snoop result) -> MESI next state for the requesting
// cache line; shared with the L2 controller.
module snoop_next_state
  import snoop_bus_initiator_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] result,
  output logic [1:0] mesi
);

  always_comb begin
    mesi = MESI_I;
    case (op)
      OP_READ:                mesi = (result == SNOOP_NOHIT) ? MESI_E : MESI_S;
      OP_INVALIDATE, OP_RWIM: mesi = MESI_M;
      default:                mesi = MESI_I;
    endcase
  end

endmodule

// File: rtl/snoop_bus_initiator.sv
// L2 bus initiator: issues a bus op, collects the peer snoop result, waits out
// a HITM writeback and reports the line's MESI state. Trace: BUS_OP_TRACE_EN.
module snoop_bus_initiator
  import snoop_bus_initiator_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 8,
  parameter int WB_TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              bus_valid,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_grant,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_result,
  input  logic              wb_done,
  output logic              resp_valid,
  output logic [1:0]        resp_state,
  output logic              resp_timeout,
  output logic              resp_illegal
);

  localparam int CNT_MAX = (SNOOP_TIMEOUT > WB_TIMEOUT) ? SNOOP_TIMEOUT : WB_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state;
  logic [2:0]       op_q;
  snoop_res_e       result_q;
  snoop_res_e       res_in;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       next_mesi;

  // The MESI lookup sees the result arriving this cycle so resp_state can be
  // registered on the same edge that enters DONE.
  always_comb begin
    res_in = result_q;
    if (state == ST_SNOOP && snoop_valid) res_in = norm_result(snoop_result);
  end

  snoop_next_state u_next_state (
    .op     (op_q),
    .result (res_in),
    .mesi   (next_mesi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= '0;
      result_q     <= SNOOP_NOHIT;
      cnt          <= '0;
      req_ready    <= 1'b1;
      bus_valid    <= 1'b0;
      bus_op       <= '0;
      bus_addr     <= '0;
      resp_valid   <= 1'b0;
      resp_state   <= '0;
      resp_timeout <= 1'b0;
      resp_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            if (is_legal_op(req_op)) begin
              state     <= ST_ISSUE;
              bus_valid <= 1'b1;
              bus_op    <= req_op;
              bus_addr  <= req_addr;
            end else begin
              state        <= ST_DONE;
              resp_valid   <= 1'b1;
              resp_state   <= MESI_I;
              resp_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus_grant) begin
            bus_valid <= 1'b0;
            if (op_q == OP_WRITE) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_state <= next_mesi;
            end else begin
              state    <= ST_SNOOP;
              cnt      <= '0;
              result_q <= SNOOP_NOHIT;
            end
          end
        end
        ST_SNOOP: begin
          if (snoop_valid) begin
            result_q <= res_in;
            if (res_in == SNOOP_HITM) begin
              state <= ST_WB_WAIT;
              cnt   <= '0;
            end else begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_state <= next_mesi;
            end
          end else if (cnt == CNT_W'(SNOOP_TIMEOUT - 1)) begin
            state        <= ST_DONE;
            resp_valid   <= 1'b1;
            resp_state   <= next_mesi;
            resp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB_WAIT: begin
          if (wb_done) begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            resp_state <= next_mesi;
          end else if (cnt == CNT_W'(WB_TIMEOUT - 1)) begin
            state        <= ST_DONE;
            resp_valid   <= 1'b1;
            resp_state   <= next_mesi;
            resp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          resp_timeout <= 1'b0;
          resp_illegal <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_OP_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && state == ST_ISSUE && bus_grant)
      $display("BusOp: %s Address: %h", bus_op_e'(op_q).name(), bus_addr);
    if (!reset && resp_valid)
      $display("SnoopResult: %s NextState: %s%s", result_q.name(),
               mesi_e'(resp_state).name(), resp_timeout ? " TIMEOUT" : "");
  end
`endif

endmodule
